// File: rtl/ahb_fifo_pkg.sv
// Shared AHB encodings and FSM state type for the AHB-to-FIFO write bridge.
package ahb_fifo_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StErr1,
    StErr2
  } state_e;

  // Both cycles of the two-cycle ERROR response drive hresp high.
  function automatic logic resp_for(state_e s);
    return ((s == StErr1) || (s == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
  endfunction

endpackage

// File: rtl/ahb_fifo_writer.sv
// AHB-Lite slave that pushes each word write straight into a FIFO.
// Define AHB_FIFO_WR_CNT_EN to add a push counter readable over AHB.
module ahb_fifo_writer
  import ahb_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CWIDTH = 16
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  input  logic [DWIDTH-1:0] hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DWIDTH-1:0] hrdata,
  output logic              fifowr,
  output logic [DWIDTH-1:0] wdata,
  input  logic              wfull
);

  if (DWIDTH < CWIDTH + 1) begin : gen_width_check
    $error("DWIDTH must hold the push counter plus the full flag");
  end

  state_e state_q;
  state_e accept_st;
  logic   hresp_q;
  logic   accept;

  assign accept = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));

  // Data-phase state implied by the address phase sampled this edge; StIdle if none.
  always_comb begin
    accept_st = StIdle;
    if (accept && hwrite) begin
      accept_st = (hsize == HSIZE_WORD) ? StWr : StErr1;
    end
    if (accept && !hwrite) begin
`ifdef AHB_FIFO_WR_CNT_EN
      accept_st = StRd;
`else
      accept_st = StErr1;
`endif
    end
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q <= StIdle;
      hresp_q <= HRESP_OKAY;
    end else begin
      unique case (state_q)
        StWr: begin
          if (!wfull) begin
            state_q <= accept_st;
            hresp_q <= resp_for(accept_st);
          end
        end
        StErr1: begin
          state_q <= StErr2;
          hresp_q <= HRESP_ERROR;
        end
        default: begin
          state_q <= accept_st;
          hresp_q <= resp_for(accept_st);
        end
      endcase
    end
  end

  assign fifowr    = (state_q == StWr) & ~wfull;
  assign hreadyout = ~((state_q == StErr1) | ((state_q == StWr) & wfull));
  assign hresp     = hresp_q;
  assign wdata     = hwdata;

`ifdef AHB_FIFO_WR_CNT_EN
  localparam logic [CWIDTH-1:0] CntOne = {{(CWIDTH-1){1'b0}}, 1'b1};

  logic [CWIDTH-1:0] cnt_q;

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      cnt_q <= '0;
    end else if (fifowr) begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  always_comb begin
    hrdata = '0;
    if (state_q == StRd) begin
      hrdata[CWIDTH:0] = {wfull, cnt_q};
    end
  end
`else
  assign hrdata = '0;
`endif

endmodule

// File: tb/tb_ahb_fifo_writer.sv
// Randomised bench for ahb_fifo_writer: an AHB master drives transactions, a
// transaction-level model predicts every data-phase cycle.
`timescale 1ns/1ps
module tb_ahb_fifo_writer;
  import ahb_fifo_pkg::*;

  localparam int DW = 32;
  localparam int CW = 8;
`ifdef AHB_FIFO_WR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          wclk = 1'b0;
  logic          wrst = 1'b0;
  logic          hsel = 1'b0;
  logic [1:0]    htrans = HTRANS_IDLE;
  logic          hwrite = 1'b0;
  logic [2:0]    hsize = 3'd0;
  logic          hready;
  logic [DW-1:0] hwdata = '0;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic          fifowr;
  logic [DW-1:0] wdata;
  logic          wfull = 1'b0;

  // Single-slave bus: the interconnect ready is this slave's ready.
  assign hready = hreadyout;

  ahb_fifo_writer #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .hsel      (hsel),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hready    (hready),
    .hwdata    (hwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .fifowr    (fifowr),
    .wdata     (wdata),
    .wfull     (wfull)
  );

  always #5 wclk = ~wclk;

  // kind: 0 no transfer, 1 word write, 2 non-word write, 3 read
  typedef struct {
    int            kind;
    logic [DW-1:0] data;
    logic [2:0]    size;
    bit            seq;
  } tx_t;

  tx_t           txq[$];
  bit            wf_pat[$];
  logic [DW-1:0] push_log[$];
  int            push_cyc[$];
  logic [DW-1:0] exp_words[$];

  bit            ad_v, dp_v, rand_full;
  tx_t           ad, dp;
  int            dp_cyc, pushes_dp, cyc;
  logic [CW-1:0] cnt_m;
  int            n_cmp, n_bad, n_stall, n_resp;
  logic [DW-1:0] last_rd;

  function automatic tx_t mk(int k, logic [DW-1:0] d, logic [2:0] s, bit q);
    tx_t t;
    t.kind = k;
    t.data = d;
    t.size = s;
    t.seq  = q;
    return t;
  endfunction

  function automatic bit is_err(int k);
    return (k == 2) || ((k == 3) && !CntEn);
  endfunction

  function automatic bit next_wfull();
    if (wf_pat.size() > 0) return wf_pat.pop_front();
    if (rand_full) return ($urandom_range(0, 3) == 0);
    return 1'b0;
  endfunction

  task automatic cmp(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_obs();
    push_log.delete();
    push_cyc.delete();
    n_stall = 0;
    n_resp  = 0;
    last_rd = '0;
  endtask

  // One bus cycle; entered and left at posedge+1.
  task automatic step();
    logic          er, es, ef;
    logic [DW-1:0] erd;
    if (!ad_v && txq.size() > 0) begin
      ad   = txq.pop_front();
      ad_v = 1'b1;
    end
    if (ad_v && ad.kind != 0) begin
      hsel   = 1'b1;
      htrans = ad.seq ? HTRANS_SEQ : HTRANS_NONSEQ;
      hwrite = (ad.kind != 3);
      hsize  = ad.size;
    end else if (ad_v && $urandom_range(0, 1) == 1) begin
      // Active transfer addressed to some other slave.
      hsel   = 1'b0;
      htrans = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
      hwrite = 1'($urandom_range(0, 1));
      hsize  = 3'($urandom_range(0, 7));
    end else begin
      hsel   = 1'($urandom_range(0, 1));
      htrans = ($urandom_range(0, 1) == 1) ? HTRANS_BUSY : HTRANS_IDLE;
      hwrite = 1'($urandom_range(0, 1));
      hsize  = 3'($urandom_range(0, 7));
    end
    hwdata = dp_v ? dp.data : DW'($urandom);
    wfull  = next_wfull();

    @(negedge wclk);
    er  = 1'b1;
    es  = HRESP_OKAY;
    ef  = 1'b0;
    erd = '0;
    if (dp_v && dp.kind == 1) begin
      ef = ~wfull;
      er = ~wfull;
    end
    if (dp_v && dp.kind == 3 && CntEn) erd[CW:0] = {wfull, cnt_m};
    if (dp_v && is_err(dp.kind)) begin
      es = HRESP_ERROR;
      er = (dp_cyc != 0);
    end
    cmp1("hreadyout", hreadyout, er);
    cmp1("hresp", hresp, es);
    cmp1("fifowr", fifowr, ef);
    cmp("hrdata", hrdata, erd);
    cmp1("fifowr_while_full", fifowr & wfull, 1'b0);
    if (ef) cmp("wdata", wdata, dp.data);

    if (!hreadyout) n_stall++;
    if (hresp) n_resp++;
    if (fifowr) begin
      push_log.push_back(wdata);
      push_cyc.push_back(cyc);
      if (dp_v) pushes_dp++;
    end
    if (dp_v && dp.kind == 3) last_rd = hrdata;
    if (ef) cnt_m = cnt_m + 1'b1;

    @(posedge wclk);
    #1;
    cyc++;
    if (dp_v && er) begin
      if (dp.kind == 1) cmp("pushes_per_write", DW'(pushes_dp), 1);
      dp_v = 1'b0;
    end else if (dp_v) begin
      dp_cyc++;
    end
    if (ad_v && (er || ad.kind == 0)) begin
      if (ad.kind != 0 && er) begin
        dp        = ad;
        dp_v      = 1'b1;
        dp_cyc    = 0;
        pushes_dp = 0;
      end
      ad_v = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((txq.size() > 0 || ad_v || dp_v) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: transfers still pending after %0d cycles", guard);
      txq.delete();
      ad_v = 1'b0;
      dp_v = 1'b0;
    end
    step();
  endtask

  // Asserted mid-cycle to check the asynchronous clear.
  task automatic apply_reset();
    wrst = 1'b0;
    #1;
    cmp1("rst_hreadyout", hreadyout, 1'b1);
    cmp1("rst_hresp", hresp, HRESP_OKAY);
    cmp1("rst_fifowr", fifowr, 1'b0);
    txq.delete();
    wf_pat.delete();
    ad_v   = 1'b0;
    dp_v   = 1'b0;
    cnt_m  = '0;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    wfull  = 1'b0;
    @(posedge wclk);
    #1;
    wrst = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] exp3[3];
    exp3 = '{32'hA1, 32'hA2, 32'hA3};
    n_cmp = 0; n_bad = 0; cyc = 0; cnt_m = '0;
    ad_v = 1'b0; dp_v = 1'b0; rand_full = 1'b0;
    clear_obs();

    #1;
    cmp1("reset_hreadyout", hreadyout, 1'b1);
    cmp1("reset_hresp", hresp, HRESP_OKAY);
    cmp1("reset_fifowr", fifowr, 1'b0);
    cmp("reset_hrdata", hrdata, '0);
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b1;
    step();

    // Three pipelined word writes, never full.
    clear_obs();
    txq.push_back(mk(1, 32'hA1, HSIZE_WORD, 1'b0));
    txq.push_back(mk(1, 32'hA2, HSIZE_WORD, 1'b1));
    txq.push_back(mk(1, 32'hA3, HSIZE_WORD, 1'b1));
    drain();
    cmp("burst_push_count", DW'(push_log.size()), 3);
    for (int i = 0; i < 3; i++)
      cmp($sformatf("burst_word%0d", i), (i < push_log.size()) ? push_log[i] : 'x, exp3[i]);
    cmp("burst_consecutive",
        (push_cyc.size() == 3) ? DW'(push_cyc[2] - push_cyc[0]) : 'x, 2);
    cmp("burst_stalls", DW'(n_stall), 0);

    // Write held off by four full cycles.
    clear_obs();
    wf_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    txq.push_back(mk(1, 32'h55, HSIZE_WORD, 1'b0));
    drain();
    cmp("stall_cycles", DW'(n_stall), 4);
    cmp("stall_push_count", DW'(push_log.size()), 1);
    cmp("stall_word", (push_log.size() > 0) ? push_log[0] : 'x, 32'h55);

    // Byte write gets the two-cycle ERROR.
    clear_obs();
    txq.push_back(mk(2, 32'h77, 3'b000, 1'b0));
    drain();
    cmp("byte_push_count", DW'(push_log.size()), 0);
    cmp("byte_wait_cycles", DW'(n_stall), 1);
    cmp("byte_error_cycles", DW'(n_resp), 2);

    // Five writes then a read of the counter.
    apply_reset();
    for (int i = 0; i < 5; i++) txq.push_back(mk(1, DW'(i + 16), HSIZE_WORD, i != 0));
    drain();
    clear_obs();
    txq.push_back(mk(3, '0, HSIZE_WORD, 1'b0));
    drain();
`ifdef AHB_FIFO_WR_CNT_EN
    cmp("read_count5", last_rd, 32'd5);
    cmp("read_wait_cycles", DW'(n_stall), 0);
    cmp("read_error_cycles", DW'(n_resp), 0);
`else
    cmp("read_wait_cycles", DW'(n_stall), 1);
    cmp("read_error_cycles", DW'(n_resp), 2);
`endif

    // Reset during a stalled write discards it.
    wf_pat = '{1'b0, 1'b1, 1'b1, 1'b1};
    txq.push_back(mk(1, 32'h99, HSIZE_WORD, 1'b0));
    repeat (3) step();
    apply_reset();
    clear_obs();
    repeat (5) step();
    cmp("post_reset_pushes", DW'(push_log.size()), 0);
    cmp("post_reset_stalls", DW'(n_stall), 0);

`ifdef AHB_FIFO_WR_CNT_EN
    // Counter wrap: all-ones then back to zero.
    for (int i = 0; i < (1 << CW) - 1; i++) txq.push_back(mk(1, DW'(i), HSIZE_WORD, 1'b1));
    txq.push_back(mk(3, '0, HSIZE_WORD, 1'b0));
    drain();
    cmp("count_all_ones", last_rd, 32'hFF);
    txq.push_back(mk(1, 32'h1, HSIZE_WORD, 1'b0));
    txq.push_back(mk(3, '0, HSIZE_WORD, 1'b0));
    drain();
    cmp("count_wrapped", last_rd, 32'h0);
`endif

    // Random mix with random FIFO backpressure.
    clear_obs();
    exp_words.delete();
    rand_full = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [2:0] s;
      logic [DW-1:0] d;
      r = $urandom_range(0, 9);
      d = DW'($urandom);
      if (r < 2) begin
        txq.push_back(mk(0, d, 3'd0, 1'b0));
      end else if (r < 7) begin
        txq.push_back(mk(1, d, HSIZE_WORD, 1'($urandom_range(0, 1))));
        exp_words.push_back(d);
      end else if (r < 9) begin
        do s = 3'($urandom_range(0, 7)); while (s == HSIZE_WORD);
        txq.push_back(mk(2, d, s, 1'($urandom_range(0, 1))));
      end else begin
        txq.push_back(mk(3, d, 3'($urandom_range(0, 7)), 1'b0));
      end
    end
    drain();
    rand_full = 1'b0;
    cmp("random_push_count", DW'(push_log.size()), DW'(exp_words.size()));
    for (int i = 0; i < exp_words.size(); i++)
      cmp("random_push_order", (i < push_log.size()) ? push_log[i] : 'x, exp_words[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
